// File: rtl/pipeline_drain.sv
// rtl/pipeline_drain.sv - credit-limited result drain for a fixed-latency CE-high pipeline
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   src_valid  upstream operand set ready to issue
//   src_take   issue strobe; pipeline input stage captures the operand set at this edge
//   pipe_dout  last-stage pipeline output (WIDTH bits)
//   m_valid    FIFO head holds a result
//   m_ready    downstream accepts the head
//   m_data     FIFO head result (WIDTH bits)
//   level      number of results stored in the FIFO
module pipeline_drain #(
  parameter int WIDTH   = 48,
  parameter int LATENCY = 4,
  parameter int DEPTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     src_valid,
  output logic                     src_take,
  input  logic [WIDTH-1:0]         pipe_dout,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [WIDTH-1:0]         m_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [LATENCY-1:0] tag;
  logic [CW-1:0]      count;
  logic [CW-1:0]      inflight;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [WIDTH-1:0]   mem [DEPTH];

  logic               push;
  logic               pop;
  logic [CW:0]        credit_used;

  // Inflight can never exceed DEPTH (credit-limited), so it shares the count width.
  // Credit uses only registered state: a pop frees credit from the next cycle.
  assign credit_used = {1'b0, count} + {1'b0, inflight};
  assign src_take    = src_valid && (credit_used < (CW+1)'(DEPTH));

  assign push    = tag[LATENCY-1];
  assign m_valid = (count != '0);
  assign pop     = m_valid && m_ready;
  assign m_data  = mem[rd_ptr];
  assign level   = count;

  // Tag shift register mirrors the data pipeline; inflight is its population count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag      <= '0;
      inflight <= '0;
    end else begin
      tag[0] <= src_take;
      for (int k = 1; k < LATENCY; k++) begin
        tag[k] <= tag[k-1];
      end
      case ({src_take, push})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Result FIFO; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= pipe_dout;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A capture into a full FIFO would mean the credit accounting is broken.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count == CW'(DEPTH))));

endmodule

// File: tb/tb_pipeline_drain.sv
// tb/tb_pipeline_drain.sv - scoreboard bench for pipeline_drain
module tb_pipeline_drain;

  localparam int WIDTH   = 48;
  localparam int LATENCY = 4;
  localparam int DEPTH   = 8;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   src_valid = 1'b0;
  logic                   m_ready = 1'b0;
  logic                   src_take;
  logic                   m_valid;
  logic [WIDTH-1:0]       pipe_dout;
  logic [WIDTH-1:0]       m_data;
  logic [WIDTH-1:0]       src_data = '0;
  logic [$clog2(DEPTH):0] level;

  logic [WIDTH-1:0]       stage [LATENCY];
  logic [WIDTH-1:0]       exp_q [$];

  int n_tests = 0;
  int n_fail = 0;
  int take_cnt = 0;
  int deliv_cnt = 0;
  logic [WIDTH-1:0] seq = 48'h1000;

  pipeline_drain #(.WIDTH(WIDTH), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_valid (src_valid),
    .src_take  (src_take),
    .pipe_dout (pipe_dout),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .level     (level)
  );

  always #5 clk = ~clk;

  // External CE-high pipeline: captures src_data every edge, never reset.
  initial begin
    for (int k = 0; k < LATENCY; k++) stage[k] = '0;
  end
  always @(posedge clk) begin
    stage[0] <= src_data;
    for (int k = 1; k < LATENCY; k++) stage[k] <= stage[k-1];
  end
  assign pipe_dout = stage[LATENCY-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [WIDTH-1:0] junk();
    return {16'($urandom), 32'($urandom)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #2;
  endtask

  // Monitor / scoreboard: credit bound first, then pop-compare, then record issue.
  always @(negedge clk) begin
    if (rst_n) begin
      check("credit_bound", 64'(exp_q.size() <= DEPTH), 64'd1);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_result: got %0h required none", m_data);
        end else begin
          check("result_data", 64'(m_data), 64'(exp_q.pop_front()));
          deliv_cnt++;
        end
      end
      if (src_take) begin
        exp_q.push_back(src_data);
        take_cnt++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    int base;
    int tbase;
    int miss;
    int gaps;
    int lvl_bad;
    int stale;
    int maxlvl;

    // Reset state
    repeat (3) step();
    look();
    check("rst_src_take", 64'(src_take), 64'd0);
    check("rst_m_valid",  64'(m_valid),  64'd0);
    check("rst_m_data",   64'(m_data),   64'd0);
    check("rst_level",    64'(level),    64'd0);
    rst_n = 1'b1;

    // T1: single issue, latency LATENCY+1
    repeat (10) step();
    src_valid = 1'b1;
    src_data  = 48'h123;
    look();
    check("t1_take", 64'(src_take), 64'd1);
    step();
    src_valid = 1'b0;
    src_data  = junk();
    step(); src_data = junk();
    step(); src_data = junk();
    step(); src_data = junk();
    look();
    check("t1_early_valid", 64'(m_valid), 64'd0);
    step();
    look();
    check("t1_valid", 64'(m_valid), 64'd1);
    check("t1_data",  64'(m_data),  64'h123);
    check("t1_level", 64'(level),   64'd1);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    look();
    check("t1_popped_valid", 64'(m_valid), 64'd0);
    check("t1_popped_level", 64'(level),   64'd0);

    // T2: full backpressure, then restart
    base      = take_cnt;
    src_valid = 1'b1;
    src_data  = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      src_data = WIDTH'(take_cnt - base);
    end
    look();
    check("t2_issued",   64'(take_cnt - base), 64'd8);
    check("t2_take_low", 64'(src_take),        64'd0);
    check("t2_level",    64'(level),           64'd8);
    m_ready = 1'b1;
    #1;
    check("t2_no_bypass", 64'(src_take), 64'd0);
    step();
    src_data = WIDTH'(take_cnt - base);
    look();
    check("t2_restart", 64'(src_take), 64'd1);
    step();
    src_valid = 1'b0;
    repeat (20) step();
    check("t2_drained_q",     64'(exp_q.size()), 64'd0);
    check("t2_drained_valid", 64'(m_valid),      64'd0);

    // T3: streaming
    src_valid = 1'b1;
    m_ready   = 1'b1;
    miss = 0; gaps = 0; lvl_bad = 0;
    for (int i = 0; i < 110; i++) begin
      if (i > 0) step();
      src_data = seq;
      seq++;
      look();
      if (!src_take) miss++;
      if (i >= LATENCY + 1) begin
        if (!m_valid) gaps++;
        if (level != 1) lvl_bad++;
      end
    end
    src_valid = 1'b0;
    check("t3_take_miss", 64'(miss),    64'd0);
    check("t3_gaps",      64'(gaps),    64'd0);
    check("t3_level",     64'(lvl_bad), 64'd0);
    repeat (10) step();
    check("t3_drained_q", 64'(exp_q.size()), 64'd0);

    // T4: pointer wrap with stall/release phases
    base = deliv_cnt;
    tbase = take_cnt;
    maxlvl = 0;
    for (int i = 0; i < 400 && (deliv_cnt - base) < 24; i++) begin
      step();
      src_valid = ((take_cnt - tbase) < 24);
      src_data  = seq;
      seq++;
      m_ready   = ((i / 12) % 2) == 1;
      look();
      if (int'(level) > maxlvl) maxlvl = int'(level);
    end
    src_valid = 1'b0;
    check("t4_delivered", 64'(deliv_cnt - base), 64'd24);
    check("t4_max_level", 64'(maxlvl),           64'd8);
    m_ready = 1'b1;
    repeat (10) step();
    check("t4_drained_q", 64'(exp_q.size()), 64'd0);

    // T5: random traffic
    for (int i = 0; i < 10000; i++) begin
      step();
      src_valid = 1'($urandom_range(0, 1));
      m_ready   = 1'($urandom_range(0, 1));
      src_data  = seq;
      seq++;
    end
    src_valid = 1'b0;
    m_ready   = 1'b1;
    repeat (20) step();
    check("t5_drained_q",     64'(exp_q.size()), 64'd0);
    check("t5_drained_valid", 64'(m_valid),      64'd0);

    // T6: reset mid-operation with inflight=3, level=5
    m_ready   = 1'b0;
    src_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      src_data = seq;
      seq++;
      step();
    end
    src_valid = 1'b0;
    src_data  = junk();
    step();
    look();
    check("t6_pre_level", 64'(level), 64'd5);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_rst_valid", 64'(m_valid),  64'd0);
    check("t6_rst_level", 64'(level),    64'd0);
    check("t6_rst_data",  64'(m_data),   64'd0);
    check("t6_rst_take",  64'(src_take), 64'd0);
    repeat (3) begin
      step();
      src_data = junk();
    end
    rst_n   = 1'b1;
    m_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      src_data = junk();
      look();
      if (m_valid) stale++;
    end
    check("t6_stale", 64'(stale), 64'd0);
    step();
    src_valid = 1'b1;
    src_data  = 48'habcdef012345;
    look();
    check("t6_fresh_take", 64'(src_take), 64'd1);
    step();
    src_valid = 1'b0;
    src_data  = junk();
    step(); src_data = junk();
    step(); src_data = junk();
    step(); src_data = junk();
    look();
    check("t6_fresh_early", 64'(m_valid), 64'd0);
    step();
    look();
    check("t6_fresh_valid", 64'(m_valid), 64'd1);
    check("t6_fresh_data",  64'(m_data),  64'habcdef012345);
    repeat (3) step();
    check("t6_drained_q", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
